// File: rtl/pipe_ex_mem_pkg.sv
// Shared definitions for the EX/MEM pipeline register and its data-memory sequencer.
package pipe_ex_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_WAIT   = 2'b10
    } mem_state_e;

    localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0800;

endpackage

// File: rtl/mem_access_fsm.sv
// Sequences one Stall/Done access per captured slot: request strobes, upstream stall
// and the load-data hold register.
module mem_access_fsm
    import pipe_ex_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_next,
    input  logic              wr_next,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              load,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              stall_mem,
    output logic [DATA_W-1:0] mem_rdata_o
);

    mem_state_e        state_q, state_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy;
    logic              done;

    always_comb begin
        busy      = (state_q == ST_ACCESS) || (state_q == ST_WAIT);
        done      = busy && mem_done;
        stall_mem = busy && !mem_done;
        load      = !stall_mem;

        // Strobes are registered at the load edge, so they last exactly the ACCESS cycle.
        if (load) begin
            state_d = (rd_next || wr_next) ? ST_ACCESS : ST_IDLE;
            rd_d    = rd_next;
            wr_d    = wr_next;
        end else begin
            state_d = ST_WAIT;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
        end

        rdata_d     = done ? mem_data_out : rdata_q;
        mem_rdata_o = done ? mem_data_out : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_rd = rd_q;
    assign mem_wr = wr_q;

endmodule

// File: rtl/pipe_ex_mem.sv
// EX/MEM pipeline register: captures execute results, squashes flushed slots and
// hands memory operations to the access sequencer.
module pipe_ex_mem
    import pipe_ex_mem_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic [DATA_W-1:0] Data_two,
    input  logic [DATA_W-1:0] bj_write_data,
    input  logic [15:0]       instruction,
    input  logic [2:0]        write_sel,
    input  logic              Reg_write,
    input  logic              Mem_read,
    input  logic              Mem_write,
    input  logic              Mem_reg,
    input  logic              JAL,
    input  logic              halt,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_done,
    input  logic              mem_stall,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              stall_mem,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic [DATA_W-1:0] ALU_result_o,
    output logic [DATA_W-1:0] Data_two_o,
    output logic [DATA_W-1:0] bj_write_data_o,
    output logic [15:0]       instruction_o,
    output logic [2:0]        write_sel_o,
    output logic              Reg_write_o,
    output logic              Mem_reg_o,
    output logic              JAL_o,
    output logic              halt_o,
    output logic              align_err_o
);

    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic [DATA_W-1:0] data_two_q, data_two_d;
    logic [DATA_W-1:0] bj_data_q, bj_data_d;
    logic [15:0]       instruction_q, instruction_d;
    logic [2:0]        write_sel_q, write_sel_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_reg_q, mem_reg_d;
    logic              jal_q, jal_d;
    logic              halt_q, halt_d;
    logic              align_err_q, align_err_d;
    logic              flush_pend_q, flush_pend_d;

    logic load;
    logic squash;
    logic rd_in, wr_in;
    logic misalign;
    logic rd_next, wr_next;
    logic mem_stall_unused;

    // The memory's busy flag is advisory; sequencing relies on mem_done alone.
    assign mem_stall_unused = mem_stall;

    always_comb begin
        // A flush seen while stalled is remembered and applied at the next load edge.
        squash   = flush || flush_pend_q;
        rd_in    = Mem_read && !squash;
        wr_in    = Mem_write && !squash;
        misalign = ALU_result[0] && (rd_in || wr_in);
        rd_next  = rd_in && !misalign && !halt;
        wr_next  = wr_in && !misalign && !halt;

        alu_result_d  = alu_result_q;
        data_two_d    = data_two_q;
        bj_data_d     = bj_data_q;
        instruction_d = instruction_q;
        write_sel_d   = write_sel_q;
        reg_write_d   = reg_write_q;
        mem_reg_d     = mem_reg_q;
        jal_d         = jal_q;
        halt_d        = halt_q;
        align_err_d   = align_err_q;
        flush_pend_d  = flush_pend_q || flush;

        if (load) begin
            alu_result_d  = ALU_result;
            data_two_d    = Data_two;
            bj_data_d     = bj_write_data;
            instruction_d = squash ? NOP_INSTR : instruction;
            write_sel_d   = write_sel;
            reg_write_d   = Reg_write && !squash && !misalign;
            mem_reg_d     = Mem_reg;
            jal_d         = JAL && !squash;
            halt_d        = halt && !squash;
            align_err_d   = misalign;
            flush_pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_q  <= '0;
            data_two_q    <= '0;
            bj_data_q     <= '0;
            instruction_q <= NOP_INSTR;
            write_sel_q   <= '0;
            reg_write_q   <= 1'b0;
            mem_reg_q     <= 1'b0;
            jal_q         <= 1'b0;
            halt_q        <= 1'b0;
            align_err_q   <= 1'b0;
            flush_pend_q  <= 1'b0;
        end else begin
            alu_result_q  <= alu_result_d;
            data_two_q    <= data_two_d;
            bj_data_q     <= bj_data_d;
            instruction_q <= instruction_d;
            write_sel_q   <= write_sel_d;
            reg_write_q   <= reg_write_d;
            mem_reg_q     <= mem_reg_d;
            jal_q         <= jal_d;
            halt_q        <= halt_d;
            align_err_q   <= align_err_d;
            flush_pend_q  <= flush_pend_d;
        end
    end

    mem_access_fsm #(
        .DATA_W(DATA_W)
    ) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .rd_next     (rd_next),
        .wr_next     (wr_next),
        .mem_done    (mem_done),
        .mem_data_out(mem_data_out),
        .load        (load),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .stall_mem   (stall_mem),
        .mem_rdata_o (mem_rdata_o)
    );

    assign mem_addr        = alu_result_q;
    assign mem_data_in     = data_two_q;
    assign ALU_result_o    = alu_result_q;
    assign Data_two_o      = data_two_q;
    assign bj_write_data_o = bj_data_q;
    assign instruction_o   = instruction_q;
    assign write_sel_o     = write_sel_q;
    assign Reg_write_o     = reg_write_q;
    assign Mem_reg_o       = mem_reg_q;
    assign JAL_o           = jal_q;
    assign halt_o          = halt_q;
    assign align_err_o     = align_err_q;

endmodule

// File: tb/tb_pipe_ex_mem.sv
// Bench for pipe_ex_mem: directed scenarios plus randomized traffic against a
// transaction-level model of the register and a latency-driven memory.
module tb_pipe_ex_mem;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [15:0] ALU_result, Data_two, bj_write_data, instruction, mem_data_out;
    logic [2:0]  write_sel;
    logic        Reg_write, Mem_read, Mem_write, Mem_reg, JAL, halt;
    logic        mem_done, mem_stall;
    logic [15:0] mem_addr, mem_data_in, mem_rdata_o;
    logic        mem_rd, mem_wr, stall_mem;
    logic [15:0] ALU_result_o, Data_two_o, bj_write_data_o, instruction_o;
    logic [2:0]  write_sel_o;
    logic        Reg_write_o, Mem_reg_o, JAL_o, halt_o, align_err_o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] alu, d2, bj, instr;
        logic [2:0]  ws;
        logic        rw, mr, jal, hlt, ae, rd, wr;
    } slot_t;

    pipe_ex_mem #(
        .DATA_W   (16),
        .NOP_INSTR(16'h0800)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ALU_result(ALU_result), .Data_two(Data_two), .bj_write_data(bj_write_data),
        .instruction(instruction), .write_sel(write_sel),
        .Reg_write(Reg_write), .Mem_read(Mem_read), .Mem_write(Mem_write),
        .Mem_reg(Mem_reg), .JAL(JAL), .halt(halt),
        .mem_data_out(mem_data_out), .mem_done(mem_done), .mem_stall(mem_stall),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .stall_mem(stall_mem), .mem_rdata_o(mem_rdata_o),
        .ALU_result_o(ALU_result_o), .Data_two_o(Data_two_o),
        .bj_write_data_o(bj_write_data_o), .instruction_o(instruction_o),
        .write_sel_o(write_sel_o), .Reg_write_o(Reg_write_o), .Mem_reg_o(Mem_reg_o),
        .JAL_o(JAL_o), .halt_o(halt_o), .align_err_o(align_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its summary in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 0; ALU_result = '0; Data_two = '0; bj_write_data = '0;
        instruction = 16'h0800; write_sel = '0; Reg_write = 0; Mem_read = 0;
        Mem_write = 0; Mem_reg = 0; JAL = 0; halt = 0; mem_data_out = '0;
        mem_done = 0; mem_stall = 0;
    endtask

    task automatic test_reset();
        flush = 0; ALU_result = 16'hFFFF; Data_two = 16'hAAAA; bj_write_data = 16'h5555;
        instruction = 16'hABCD; write_sel = 3'd7; Reg_write = 1; Mem_read = 1; Mem_write = 0;
        Mem_reg = 1; JAL = 1; halt = 0; mem_data_out = 16'h1357; mem_done = 1; mem_stall = 1;
        rst = 1;
        step();
        step();
        rst = 0;
        clear_inputs();
        #1;
        n_cmp++; if (instruction_o !== 16'h0800) begin n_err++; $display("FAIL reset_instr got=%h want=0800", instruction_o); end
        n_cmp++; if (ALU_result_o !== 16'h0) begin n_err++; $display("FAIL reset_alu got=%h want=0000", ALU_result_o); end
        n_cmp++; if (Data_two_o !== 16'h0) begin n_err++; $display("FAIL reset_d2 got=%h want=0000", Data_two_o); end
        n_cmp++; if (bj_write_data_o !== 16'h0) begin n_err++; $display("FAIL reset_bj got=%h want=0000", bj_write_data_o); end
        n_cmp++; if (write_sel_o !== 3'd0) begin n_err++; $display("FAIL reset_ws got=%h want=0", write_sel_o); end
        n_cmp++; if ({Reg_write_o, Mem_reg_o, JAL_o, halt_o, align_err_o} !== 5'b0) begin n_err++; $display("FAIL reset_ctrl got=%b want=00000", {Reg_write_o, Mem_reg_o, JAL_o, halt_o, align_err_o}); end
        n_cmp++; if ({mem_rd, mem_wr, stall_mem} !== 3'b0) begin n_err++; $display("FAIL reset_strobes got=%b want=000", {mem_rd, mem_wr, stall_mem}); end
        n_cmp++; if (mem_rdata_o !== 16'h0) begin n_err++; $display("FAIL reset_rdata got=%h want=0000", mem_rdata_o); end
    endtask

    task automatic test_load_hit();
        clear_inputs();
        Mem_read = 1; Reg_write = 1; Mem_reg = 1; ALU_result = 16'h0040;
        instruction = 16'h8A40; write_sel = 3'd5;
        step();
        clear_inputs();
        mem_done = 1; mem_data_out = 16'hBEEF;
        #1;
        n_cmp++; if (mem_rd !== 1'b1) begin n_err++; $display("FAIL hit_rd got=%b want=1", mem_rd); end
        n_cmp++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL hit_stall got=%b want=0", stall_mem); end
        n_cmp++; if (mem_addr !== 16'h0040) begin n_err++; $display("FAIL hit_addr got=%h want=0040", mem_addr); end
        n_cmp++; if (mem_rdata_o !== 16'hBEEF) begin n_err++; $display("FAIL hit_rdata got=%h want=beef", mem_rdata_o); end
        n_cmp++; if ({Reg_write_o, Mem_reg_o, write_sel_o} !== 5'b11101) begin n_err++; $display("FAIL hit_ctrl got=%b want=11101", {Reg_write_o, Mem_reg_o, write_sel_o}); end
        step();
        mem_done = 0; mem_data_out = 16'h0000;
        #1;
        n_cmp++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL hit_rd_after got=%b want=0", mem_rd); end
        n_cmp++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL hit_stall_after got=%b want=0", stall_mem); end
        n_cmp++; if (mem_rdata_o !== 16'hBEEF) begin n_err++; $display("FAIL hit_rdata_hold got=%h want=beef", mem_rdata_o); end
    endtask

    task automatic test_store_miss();
        clear_inputs();
        Mem_write = 1; Data_two = 16'h1234; ALU_result = 16'h0100; instruction = 16'h9100;
        step();
        clear_inputs();
        instruction = 16'h4321; Reg_write = 1; ALU_result = 16'h0200;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (stall_mem !== 1'b1) begin n_err++; $display("FAIL miss_stall[%0d] got=%b want=1", i, stall_mem); end
            n_cmp++; if (mem_wr !== (i == 0)) begin n_err++; $display("FAIL miss_wr[%0d] got=%b want=%b", i, mem_wr, (i == 0)); end
            n_cmp++; if ({mem_addr, mem_data_in} !== {16'h0100, 16'h1234}) begin n_err++; $display("FAIL miss_hold[%0d] got=%h/%h want=0100/1234", i, mem_addr, mem_data_in); end
            n_cmp++; if (instruction_o !== 16'h9100) begin n_err++; $display("FAIL miss_instr[%0d] got=%h want=9100", i, instruction_o); end
            step();
        end
        mem_done = 1;
        #1;
        n_cmp++; if ({stall_mem, mem_wr} !== 2'b00) begin n_err++; $display("FAIL miss_done got=%b want=00", {stall_mem, mem_wr}); end
        step();
        mem_done = 0;
        #1;
        n_cmp++; if (instruction_o !== 16'h4321) begin n_err++; $display("FAIL miss_next_instr got=%h want=4321", instruction_o); end
        n_cmp++; if (ALU_result_o !== 16'h0200) begin n_err++; $display("FAIL miss_next_alu got=%h want=0200", ALU_result_o); end
        n_cmp++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL miss_next_stall got=%b want=0", stall_mem); end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        Mem_read = 1; ALU_result = 16'h0010;
        step();
        ALU_result = 16'h0012; mem_done = 1; mem_data_out = 16'h1111;
        #1;
        n_cmp++; if ({mem_rd, stall_mem} !== 2'b10) begin n_err++; $display("FAIL b2b_first got=%b want=10", {mem_rd, stall_mem}); end
        n_cmp++; if (mem_addr !== 16'h0010) begin n_err++; $display("FAIL b2b_addr0 got=%h want=0010", mem_addr); end
        n_cmp++; if (mem_rdata_o !== 16'h1111) begin n_err++; $display("FAIL b2b_rdata0 got=%h want=1111", mem_rdata_o); end
        step();
        Mem_read = 0; ALU_result = 16'h0; mem_data_out = 16'h2222;
        #1;
        n_cmp++; if ({mem_rd, stall_mem} !== 2'b10) begin n_err++; $display("FAIL b2b_second got=%b want=10", {mem_rd, stall_mem}); end
        n_cmp++; if (mem_addr !== 16'h0012) begin n_err++; $display("FAIL b2b_addr1 got=%h want=0012", mem_addr); end
        n_cmp++; if (mem_rdata_o !== 16'h2222) begin n_err++; $display("FAIL b2b_rdata1 got=%h want=2222", mem_rdata_o); end
        step();
        mem_done = 0;
        #1;
        n_cmp++; if ({mem_rd, stall_mem} !== 2'b00) begin n_err++; $display("FAIL b2b_end got=%b want=00", {mem_rd, stall_mem}); end
    endtask

    task automatic test_misaligned();
        clear_inputs();
        Mem_read = 1; Reg_write = 1; ALU_result = 16'h0003; instruction = 16'h8803;
        step();
        clear_inputs();
        #1;
        n_cmp++; if (align_err_o !== 1'b1) begin n_err++; $display("FAIL mis_err got=%b want=1", align_err_o); end
        n_cmp++; if ({mem_rd, stall_mem} !== 2'b00) begin n_err++; $display("FAIL mis_access got=%b want=00", {mem_rd, stall_mem}); end
        n_cmp++; if (Reg_write_o !== 1'b0) begin n_err++; $display("FAIL mis_rw got=%b want=0", Reg_write_o); end
        n_cmp++; if (instruction_o !== 16'h8803) begin n_err++; $display("FAIL mis_instr got=%h want=8803", instruction_o); end
        step();
        #1;
        n_cmp++; if (align_err_o !== 1'b0) begin n_err++; $display("FAIL mis_clear got=%b want=0", align_err_o); end
    endtask

    task automatic test_flush_during_stall();
        clear_inputs();
        Mem_read = 1; Reg_write = 1; ALU_result = 16'h0020; instruction = 16'h2222;
        step();
        clear_inputs();
        instruction = 16'h5555; Reg_write = 1; ALU_result = 16'h0030;
        #1;
        n_cmp++; if (stall_mem !== 1'b1) begin n_err++; $display("FAIL fl_access_stall got=%b want=1", stall_mem); end
        step();
        flush = 1;
        #1;
        n_cmp++; if (stall_mem !== 1'b1) begin n_err++; $display("FAIL fl_wait0_stall got=%b want=1", stall_mem); end
        step();
        flush = 0;
        #1;
        n_cmp++; if (stall_mem !== 1'b1) begin n_err++; $display("FAIL fl_wait1_stall got=%b want=1", stall_mem); end
        step();
        mem_done = 1; mem_data_out = 16'hABCD;
        #1;
        n_cmp++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL fl_done_stall got=%b want=0", stall_mem); end
        n_cmp++; if (mem_rdata_o !== 16'hABCD) begin n_err++; $display("FAIL fl_rdata got=%h want=abcd", mem_rdata_o); end
        n_cmp++; if ({instruction_o, Reg_write_o} !== {16'h2222, 1'b1}) begin n_err++; $display("FAIL fl_inflight got=%h/%b want=2222/1", instruction_o, Reg_write_o); end
        step();
        mem_done = 0;
        #1;
        n_cmp++; if (instruction_o !== 16'h0800) begin n_err++; $display("FAIL fl_squash_instr got=%h want=0800", instruction_o); end
        n_cmp++; if (Reg_write_o !== 1'b0) begin n_err++; $display("FAIL fl_squash_rw got=%b want=0", Reg_write_o); end
        n_cmp++; if (ALU_result_o !== 16'h0030) begin n_err++; $display("FAIL fl_squash_alu got=%h want=0030", ALU_result_o); end
    endtask

    task automatic test_reset_mid_wait();
        clear_inputs();
        Mem_read = 1; Reg_write = 1; ALU_result = 16'h0050; instruction = 16'h3333;
        step();
        clear_inputs();
        step();
        #1;
        n_cmp++; if (stall_mem !== 1'b1) begin n_err++; $display("FAIL rw_wait_stall got=%b want=1", stall_mem); end
        rst = 1;
        step();
        rst = 0;
        #1;
        n_cmp++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL rw_stall got=%b want=0", stall_mem); end
        n_cmp++; if (instruction_o !== 16'h0800) begin n_err++; $display("FAIL rw_instr got=%h want=0800", instruction_o); end
        n_cmp++; if ({ALU_result_o, Reg_write_o, mem_rd} !== 18'h0) begin n_err++; $display("FAIL rw_outs got=%h/%b/%b want=0", ALU_result_o, Reg_write_o, mem_rd); end
        n_cmp++; if (mem_rdata_o !== 16'h0) begin n_err++; $display("FAIL rw_rdata got=%h want=0000", mem_rdata_o); end
        step();
        #1;
        n_cmp++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL rw_idle got=%b want=0", stall_mem); end
    endtask

    task automatic test_random();
        slot_t       exp;
        bit          busy, first, flush_seen;
        int          lat;
        logic [15:0] last_rdata;
        logic        squash, rd_in, wr_in, mis, stall_exp;
        clear_inputs();
        rst = 1;
        step();
        rst = 0;
        exp = '{default: '0};
        exp.instr = 16'h0800;
        busy = 0; first = 0; flush_seen = 0; lat = 0; last_rdata = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            n_cmp++; if ({instruction_o, ALU_result_o, Data_two_o, bj_write_data_o} !== {exp.instr, exp.alu, exp.d2, exp.bj}) begin n_err++; $display("FAIL rnd_data[%0d] got=%h %h %h %h want=%h %h %h %h", cyc, instruction_o, ALU_result_o, Data_two_o, bj_write_data_o, exp.instr, exp.alu, exp.d2, exp.bj); end
            n_cmp++; if ({write_sel_o, Reg_write_o, Mem_reg_o, JAL_o, halt_o, align_err_o} !== {exp.ws, exp.rw, exp.mr, exp.jal, exp.hlt, exp.ae}) begin n_err++; $display("FAIL rnd_ctrl[%0d] got=%b want=%b", cyc, {write_sel_o, Reg_write_o, Mem_reg_o, JAL_o, halt_o, align_err_o}, {exp.ws, exp.rw, exp.mr, exp.jal, exp.hlt, exp.ae}); end

            ALU_result = 16'($urandom); Data_two = 16'($urandom); bj_write_data = 16'($urandom);
            instruction = 16'($urandom); write_sel = 3'($urandom);
            Reg_write = 1'($urandom); Mem_reg = 1'($urandom); JAL = 1'($urandom);
            Mem_read = ($urandom_range(0, 2) == 0); Mem_write = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 5) == 0); halt = ($urandom_range(0, 7) == 0);
            mem_stall = 1'($urandom); mem_data_out = 16'($urandom);
            mem_done = busy ? (lat == 0) : ($urandom_range(0, 7) == 0);
            #1;
            stall_exp = busy && !mem_done;
            n_cmp++; if ({stall_mem, mem_rd, mem_wr} !== {stall_exp, busy && first && exp.rd, busy && first && exp.wr}) begin n_err++; $display("FAIL rnd_seq[%0d] got=%b want=%b", cyc, {stall_mem, mem_rd, mem_wr}, {stall_exp, busy && first && exp.rd, busy && first && exp.wr}); end
            n_cmp++; if ({mem_addr, mem_data_in} !== {exp.alu, exp.d2}) begin n_err++; $display("FAIL rnd_bus[%0d] got=%h/%h want=%h/%h", cyc, mem_addr, mem_data_in, exp.alu, exp.d2); end
            n_cmp++; if (mem_rdata_o !== ((busy && mem_done) ? mem_data_out : last_rdata)) begin n_err++; $display("FAIL rnd_rdata[%0d] got=%h want=%h", cyc, mem_rdata_o, (busy && mem_done) ? mem_data_out : last_rdata); end

            if (busy && mem_done) last_rdata = mem_data_out;
            if (!stall_exp) begin
                squash = flush || flush_seen;
                rd_in = Mem_read && !squash;
                wr_in = Mem_write && !squash;
                mis = ALU_result[0] && (rd_in || wr_in);
                exp.alu = ALU_result; exp.d2 = Data_two; exp.bj = bj_write_data;
                exp.instr = squash ? 16'h0800 : instruction;
                exp.ws = write_sel; exp.mr = Mem_reg;
                exp.rw = Reg_write && !squash && !mis;
                exp.jal = JAL && !squash;
                exp.hlt = halt && !squash;
                exp.ae = mis;
                exp.rd = rd_in && !mis && !halt;
                exp.wr = wr_in && !mis && !halt;
                busy = exp.rd || exp.wr;
                first = 1;
                lat = $urandom_range(0, 3);
                flush_seen = 0;
            end else begin
                if (flush) flush_seen = 1;
                first = 0;
                lat--;
            end
            step();
        end
        clear_inputs();
    endtask

    initial begin
        rst = 0;
        clear_inputs();
        test_reset();
        test_load_hit();
        test_store_miss();
        test_back_to_back();
        test_misaligned();
        test_flush_during_stall();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
